// File: rtl/decade_down_timer.sv
// decade_down_timer: loadable cascaded BCD down-counter with zero flag,
// one-cycle expiry pulse, optional auto-reload and non-BCD load rejection.
module decade_down_timer #(
  parameter int DIGITS      = 2,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                zero,
  output logic                done,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] BCD_ZERO = {W{1'b0}};
  localparam logic [W-1:0] BCD_ONE  = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state_r, state_s;
  logic [W-1:0]   count_r, count_s;
  logic [W-1:0]   reload_r, reload_s;
  logic           zero_r;
  logic           done_r, done_s;
  logic           err_r, err_s;

  // True when every nibble of v is a legal BCD digit (0..9).
  function automatic logic is_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // BCD decrement by one; a 0 digit wraps to 9 and borrows from the next.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Next-state logic: load beats en, en beats hold.
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    reload_s = reload_r;
    err_s    = err_r;
    done_s   = 1'b0;
    if (load) begin
      if (is_bcd(load_val)) begin
        count_s  = load_val;
        reload_s = load_val;
        err_s    = 1'b0;
        state_s  = (load_val != BCD_ZERO) ? RUN : IDLE;
      end else begin
        // Rejected load leaves the countdown untouched.
        err_s = 1'b1;
      end
    end else if (en) begin
      case (state_r)
        RUN: begin
          count_s = bcd_dec(count_r);
          if (count_r == BCD_ONE) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = RUN;
          end
        end
        IDLE: begin
          if ((AUTO_RELOAD == 1'b1) && (reload_r != BCD_ZERO)) begin
            count_s = reload_r;
            state_s = RUN;
          end else begin
            // No underflow: parked at zero.
            count_s = BCD_ZERO;
            state_s = IDLE;
          end
        end
        default: begin
          count_s = BCD_ZERO;
          state_s = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      count_r  <= BCD_ZERO;
      reload_r <= BCD_ZERO;
      zero_r   <= 1'b1;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      count_r  <= count_s;
      reload_r <= reload_s;
      zero_r   <= (state_s == IDLE);
      done_r   <= done_s;
      err_r    <= err_s;
    end
  end

  assign count    = count_r;
  assign zero     = zero_r;
  assign done     = done_r;
  assign load_err = err_r;

endmodule

// File: tb/tb_decade_down_timer.sv
// Self-checking bench: two timers (hold-at-zero and auto-reload) driven by
// the same inputs and compared against a decimal-arithmetic reference model.
module tb_decade_down_timer;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;

  logic         clock;
  logic         reset;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;

  logic [W-1:0] count_h, count_a;
  logic         zero_h, zero_a, done_h, done_a, err_h, err_a;

  int n_checks;
  int n_pass;

  // Reference model state, index 0 = hold variant, 1 = auto-reload variant.
  int m_cnt [2];
  int m_rel [2];
  bit m_done[2];
  bit m_err [2];

  decade_down_timer #(.DIGITS(DIGITS), .AUTO_RELOAD(1'b0)) dut_hold (
    .clock(clock), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .count(count_h), .zero(zero_h), .done(done_h), .load_err(err_h)
  );

  decade_down_timer #(.DIGITS(DIGITS), .AUTO_RELOAD(1'b1)) dut_auto (
    .clock(clock), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .count(count_a), .zero(zero_a), .done(done_a), .load_err(err_a)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] v);
    int r;
    int p;
    r = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r = r + int'(v[4*i +: 4]) * p;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d]  = 0;
      m_rel[d]  = 0;
      m_done[d] = 1'b0;
      m_err[d]  = 1'b0;
    end
  endtask

  // Advance the model by one rising edge using the current inputs.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      m_done[d] = 1'b0;
      if (load) begin
        if (bcd_ok(load_val)) begin
          m_cnt[d] = from_bcd(load_val);
          m_rel[d] = m_cnt[d];
          m_err[d] = 1'b0;
        end else begin
          m_err[d] = 1'b1;
        end
      end else if (en) begin
        if (m_cnt[d] > 0) begin
          m_cnt[d]  = m_cnt[d] - 1;
          m_done[d] = (m_cnt[d] == 0);
        end else if (d == 1 && m_rel[d] != 0) begin
          m_cnt[d] = m_rel[d];
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".count_h"}, 32'(count_h), 32'(to_bcd(m_cnt[0])));
    check_val({tag, ".zero_h"},  32'(zero_h),  32'(m_cnt[0] == 0));
    check_val({tag, ".done_h"},  32'(done_h),  32'(m_done[0]));
    check_val({tag, ".err_h"},   32'(err_h),   32'(m_err[0]));
    check_val({tag, ".count_a"}, 32'(count_a), 32'(to_bcd(m_cnt[1])));
    check_val({tag, ".zero_a"},  32'(zero_a),  32'(m_cnt[1] == 0));
    check_val({tag, ".done_a"},  32'(done_a),  32'(m_done[1]));
    check_val({tag, ".err_a"},   32'(err_a),   32'(m_err[1]));
  endtask

  // Drive inputs (called just after a falling edge), clock once, check.
  task automatic step(input string tag, input logic e, input logic l,
                      input logic [W-1:0] v);
    en       = e;
    load     = l;
    load_val = v;
    @(posedge clock);
    if (!reset) model_edge();
    @(negedge clock);
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] rv;
    logic         re;
    logic         rl;
    n_checks = 0;
    n_pass   = 0;
    en       = 1'b0;
    load     = 1'b0;
    load_val = '0;
    reset    = 1'b1;
    model_reset();
    #1;
    check_all("in_reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 8'h00);

    // Load 12 and count all the way down, then a few idle-enabled edges.
    step("load12", 1'b0, 1'b1, 8'h12);
    for (int i = 0; i < 15; i++) step("run12", 1'b1, 1'b0, 8'h00);

    // Reach 07, reject 1A while counting, then a valid 05.
    step("load10", 1'b0, 1'b1, 8'h10);
    for (int i = 0; i < 3; i++) step("to07", 1'b1, 1'b0, 8'h00);
    step("bad1A", 1'b1, 1'b1, 8'h1A);
    step("after_bad", 1'b1, 1'b0, 8'h00);
    step("after_bad", 1'b1, 1'b0, 8'h00);
    step("bad_A0", 1'b0, 1'b1, 8'hA0);
    step("load05", 1'b0, 1'b1, 8'h05);

    // Auto-reload period with 03.
    step("load03", 1'b0, 1'b1, 8'h03);
    for (int i = 0; i < 10; i++) step("ar03", 1'b1, 1'b0, 8'h00);

    // Load wins over en.
    step("load40", 1'b0, 1'b1, 8'h40);
    step("load25en", 1'b1, 1'b1, 8'h25);
    step("dec25", 1'b1, 1'b0, 8'h00);
    step("load10", 1'b0, 1'b1, 8'h10);
    step("borrow", 1'b1, 1'b0, 8'h00);

    // Asynchronous reset mid-cycle at 37.
    step("load37", 1'b0, 1'b1, 8'h37);
    step("hold37", 1'b0, 1'b0, 8'h00);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clock);
    reset = 1'b0;
    step("load00", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) step("idle00", 1'b1, 1'b0, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      re = ($urandom_range(0, 3) != 0);
      rl = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       rv = W'($urandom_range(0, 255));
        1:       rv = to_bcd($urandom_range(0, 99));
        default: rv = to_bcd($urandom_range(0, 6));
      endcase
      step("rand", re, rl, rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
